imm_split_seq: RTL
==================

// Module: imm_split_seq
// PURPOSE
//  Inverse of the immediate extender: splits a 32-bit constant into the U/I immediate pair that the
//  extender reconstructs. Emits a LUI/ADDI instruction sequence.
//  Sits in the constant-materialisation path (assembler/boot-ROM helper, test stimulus generator).
//  Output feeds the decode/extend stage.
//  Recombination rule the bench relies on: {imm20,12'b0} + sext(imm12) == constant (mod 2^32).
// PARAMETERS
//  OPC_LUI    7'b0110111  opcode placed in U-type beats
//  OPC_OPIMM  7'b0010011  opcode placed in I-type (ADDI, funct3=000) beats
// PORTS
//  clk          in   1   system clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  in_valid     in   1   constant request valid
//  in_ready     out  1   block can accept a request
//  in_const     in   32  constant to materialise
//  in_rd        in   5   destination register index
//  out_valid    out  1   instruction beat valid
//  out_ready    in   1   consumer accepts beat
//  out_instr    out  32  encoded instruction word
//  out_imm20    out  20  U immediate of this beat (0 on I beats)
//  out_imm12    out  12  I immediate of this beat (0 on U beats)
//  out_imm_src  out  1   1 = U beat (matches extender Imm_Src), 0 = I beat
//  out_last     out  1   final beat of the sequence
// BEHAVIOUR
//  - Reset: state IDLE; out_valid=0, out_last=0, out_imm_src=0, out_instr/out_imm20/out_imm12=0, in_ready=1.
//  - Arithmetic: lo=in_const[11:0]; hi=(in_const+32'h800)>>12, truncated to 20 bits.
//    The carry out of bit 31 is discarded (e.g. 0xFFFFF800 -> hi=0x00000, lo=0x800).
//  - FSM: IDLE -> U_BEAT -> I_BEAT -> IDLE.
//  - in_ready=1 only in IDLE. The request is captured on the in_valid&&in_ready edge.
//    First beat is valid on the next cycle (latency 1). Outputs are registered.
//  - A beat holds stable while out_valid && !out_ready. The FSM advances only on out_valid && out_ready.
//  - U beat:  out_instr = {hi, rd, OPC_LUI}.
//    I beat after U: out_instr = {lo, rd, 3'b000, rd, OPC_OPIMM}.
//  - out_last=1 only on the final beat. After its handshake: out_valid=0 and in_ready=1 next cycle.
//    There is no overlap of requests.
//  - rd=0 is encoded unchanged (harmless writes to x0).
//  - rst_n low mid-sequence: the in-flight request is dropped and the block returns to reset values asynchronously.
// CONFIGURATION
//  IMM_SPLIT_OPT_EN defined:
//    - hi==0: single beat ADDI rd,x0,lo (rs1=0, imm_src=0, last=1).
//    - lo==0 and hi!=0: single LUI beat (last=1).
//    - otherwise two beats.
//  IMM_SPLIT_OPT_EN undefined: always two beats LUI then ADDI rd,rd,lo, even when hi or lo is zero.
// STRUCTURE
//  - Package imm_split_pkg: OPC_LUI/OPC_OPIMM/F3_ADDI constants, state_t enum {IDLE,U_BEAT,I_BEAT}, 32/20/12 width localparams.
//  - Sub-module imm_split_calc: combinational in_const -> {hi,lo,hi_zero,lo_zero}.
//  - The top holds the request register, the FSM and the output registers.
// TESTING
//  1. in_const=0x12345678, rd=5 -> beat0 instr 0x123452B7 imm20=0x12345 src=1;
//     beat1 instr 0x67828293 imm12=0x678 last=1.
//  2. in_const=0xDEADBEEF, rd=1 -> hi=0xDEADC, lo=0xEEF.
//     Check recombination == 0xDEADBEEF (sign-carry correction).
//  3. in_const=0xFFFFF800 -> hi=0x00000, lo=0x800.
//     OPT_EN: one beat ADDI rd,x0,-2048; no OPT_EN: LUI 0 then ADDI.
//  4. out_ready held low 5 cycles during beat0 -> out_instr/out_imm* stable, in_ready=0.
//     in_valid pulses are ignored.
//  5. rst_n low while in I_BEAT -> out_valid=0 immediately, in_ready=1.
//     Next request encodes cleanly.
//  6. Random 10k constants with random out_ready -> every sequence recombines to in_const.
//     Beat count matches the macro setting.

Source files
------------

// File: rtl/imm_split_pkg.sv
// Shared constants, state encoding and instruction encoders for the LUI/ADDI constant splitter.
package imm_split_pkg;
  localparam int DATA_W = 32;
  localparam int HI_W   = 20;
  localparam int LO_W   = 12;
  localparam int RD_W   = 5;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [2:0] F3_ADDI   = 3'b000;

  typedef enum logic [1:0] {IDLE, U_BEAT, I_BEAT} state_t;

  function automatic logic [DATA_W-1:0] enc_u(input logic [HI_W-1:0] hi, input logic [RD_W-1:0] rd);
    return {hi, rd, OPC_LUI};
  endfunction

  function automatic logic [DATA_W-1:0] enc_i(input logic [LO_W-1:0] lo, input logic [RD_W-1:0] rs1,
                                              input logic [RD_W-1:0] rd);
    return {lo, rs1, F3_ADDI, rd, OPC_OPIMM};
  endfunction
endpackage

// File: rtl/imm_split_seq_if.sv
// Request/beat handshake bundle of imm_split_seq; slave is the block side, master the producer/consumer side.
interface imm_split_seq_if import imm_split_pkg::*; ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_const;
  logic [RD_W-1:0]   in_rd;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [HI_W-1:0]   out_imm20;
  logic [LO_W-1:0]   out_imm12;
  logic              out_imm_src;
  logic              out_last;

  modport slave (
    input  in_valid, in_const, in_rd, out_ready,
    output in_ready, out_valid, out_instr, out_imm20, out_imm12, out_imm_src, out_last
  );

  modport master (
    output in_valid, in_const, in_rd, out_ready,
    input  in_ready, out_valid, out_instr, out_imm20, out_imm12, out_imm_src, out_last
  );
endinterface

// File: rtl/imm_split_calc.sv
// Combinational split of a 32-bit constant into a LUI upper part and a sign-extended ADDI lower part.
module imm_split_calc import imm_split_pkg::*; (
  input  logic [DATA_W-1:0] i_const,
  output logic [HI_W-1:0]   o_hi,
  output logic [LO_W-1:0]   o_lo,
  output logic              o_hi_zero,
  output logic              o_lo_zero
);
  logic [DATA_W-1:0] w_sum;

  // Adding 0x800 pre-compensates the sign extension of lo; carry out of bit 31 wraps away.
  assign w_sum     = i_const + DATA_W'(32'h800);
  assign o_hi      = w_sum[DATA_W-1:LO_W];
  assign o_lo      = i_const[LO_W-1:0];
  assign o_hi_zero = (o_hi == '0);
  assign o_lo_zero = (o_lo == '0);
endmodule

// File: rtl/imm_split_seq.sv
// Emits a LUI/ADDI beat sequence materialising a 32-bit constant into rd.
// Optional IMM_SPLIT_OPT_EN collapses the sequence to one beat when hi or lo is zero.
module imm_split_seq import imm_split_pkg::*; (
  input logic           clk,
  input logic           rst_n,
  imm_split_seq_if.slave bus
);
  logic [HI_W-1:0]   w_hi;
  logic [LO_W-1:0]   w_lo;
  logic              w_hi_zero;
  logic              w_lo_zero;

  state_t            r_state;
  logic [RD_W-1:0]   r_rd;
  logic [LO_W-1:0]   r_lo;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_instr;
  logic [HI_W-1:0]   r_imm20;
  logic [LO_W-1:0]   r_imm12;
  logic              r_imm_src;
  logic              r_last;
  logic              w_beat_done;

  imm_split_calc u_calc (
    .i_const   (bus.in_const),
    .o_hi      (w_hi),
    .o_lo      (w_lo),
    .o_hi_zero (w_hi_zero),
    .o_lo_zero (w_lo_zero)
  );

`ifndef IMM_SPLIT_OPT_EN
  logic w_unused_zero;
  assign w_unused_zero = w_hi_zero ^ w_lo_zero;
`endif

  assign w_beat_done = r_out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rd        <= '0;
      r_lo        <= '0;
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_imm20     <= '0;
      r_imm12     <= '0;
      r_imm_src   <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_rd        <= bus.in_rd;
            r_lo        <= w_lo;
            r_out_valid <= 1'b1;
`ifdef IMM_SPLIT_OPT_EN
            if (w_hi_zero) begin
              // Upper part vanishes: a lone ADDI from x0 carries the whole value.
              r_state     <= I_BEAT;
              r_out_instr <= enc_i(w_lo, '0, bus.in_rd);
              r_imm20     <= '0;
              r_imm12     <= w_lo;
              r_imm_src   <= 1'b0;
              r_last      <= 1'b1;
            end else begin
              r_state     <= U_BEAT;
              r_out_instr <= enc_u(w_hi, bus.in_rd);
              r_imm20     <= w_hi;
              r_imm12     <= '0;
              r_imm_src   <= 1'b1;
              r_last      <= w_lo_zero;
            end
`else
            r_state     <= U_BEAT;
            r_out_instr <= enc_u(w_hi, bus.in_rd);
            r_imm20     <= w_hi;
            r_imm12     <= '0;
            r_imm_src   <= 1'b1;
            r_last      <= 1'b0;
`endif
          end
        end
        U_BEAT: begin
          if (w_beat_done) begin
            if (r_last) begin
              r_state     <= IDLE;
              r_out_valid <= 1'b0;
              r_out_instr <= '0;
              r_imm20     <= '0;
              r_imm12     <= '0;
              r_imm_src   <= 1'b0;
              r_last      <= 1'b0;
            end else begin
              r_state     <= I_BEAT;
              r_out_instr <= enc_i(r_lo, r_rd, r_rd);
              r_imm20     <= '0;
              r_imm12     <= r_lo;
              r_imm_src   <= 1'b0;
              r_last      <= 1'b1;
            end
          end
        end
        I_BEAT: begin
          if (w_beat_done) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_imm20     <= '0;
            r_imm12     <= '0;
            r_imm_src   <= 1'b0;
            r_last      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = (r_state == IDLE);
  assign bus.out_valid   = r_out_valid;
  assign bus.out_instr   = r_out_instr;
  assign bus.out_imm20   = r_imm20;
  assign bus.out_imm12   = r_imm12;
  assign bus.out_imm_src = r_imm_src;
  assign bus.out_last    = r_last;
endmodule
